// File: rtl/regfile_dump_reader.sv
// Walks a register address range through one regfile read port and streams each word out on valid/ready.
// Optional trailing XOR checksum beat when REGFILE_DUMP_CSUM_EN is defined.
module regfile_dump_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
`ifdef REGFILE_DUMP_CSUM_EN
        , CSUM
`endif
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic [ADDR_W-1:0] end_ptr, end_ptr_n;
    logic [DATA_W-1:0] data_n;
    logic [ADDR_W-1:0] addr_n;
    logic              valid_n, last_n, busy_n, done_n;
    logic              is_final, is_final_n;
    logic              capture, finish;
`ifdef REGFILE_DUMP_CSUM_EN
    logic [DATA_W-1:0] csum, csum_n;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            end_ptr  <= '0;
            m_data   <= '0;
            m_addr   <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            is_final <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef REGFILE_DUMP_CSUM_EN
            csum     <= '0;
`endif
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            end_ptr  <= end_ptr_n;
            m_data   <= data_n;
            m_addr   <= addr_n;
            m_valid  <= valid_n;
            m_last   <= last_n;
            is_final <= is_final_n;
            busy     <= busy_n;
            done     <= done_n;
`ifdef REGFILE_DUMP_CSUM_EN
            csum     <= csum_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        end_ptr_n  = end_ptr;
        data_n     = m_data;
        addr_n     = m_addr;
        valid_n    = m_valid;
        last_n     = m_last;
        is_final_n = is_final;
        busy_n     = busy;
        done_n     = 1'b0;
        capture    = 1'b0;
        finish     = 1'b0;
        rf_addr    = '0;
`ifdef REGFILE_DUMP_CSUM_EN
        csum_n     = csum;
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    ptr_n     = first_addr;
                    end_ptr_n = last_addr;
                    busy_n    = 1'b1;
`ifdef REGFILE_DUMP_CSUM_EN
                    csum_n    = '0;
`endif
                    state_n   = LOAD;
                end
            end
            LOAD: begin
                rf_addr = ptr;
                capture = 1'b1;
                state_n = SEND;
            end
            SEND: begin
                rf_addr = ptr;
                if (m_valid && m_ready) begin
                    // Back-to-back capture on handshake keeps one beat per clock.
                    if (!is_final) begin
                        capture = 1'b1;
                    end else begin
`ifdef REGFILE_DUMP_CSUM_EN
                        data_n  = csum;
                        addr_n  = '0;
                        last_n  = 1'b1;
                        state_n = CSUM;
`else
                        finish  = 1'b1;
`endif
                    end
                end
            end
`ifdef REGFILE_DUMP_CSUM_EN
            CSUM: begin
                if (m_valid && m_ready) begin
                    finish = 1'b1;
                end
            end
`endif
            default: state_n = IDLE;
        endcase

        if (capture) begin
            data_n     = rf_rdata;
            addr_n     = ptr;
            valid_n    = 1'b1;
            is_final_n = (ptr == end_ptr);
`ifdef REGFILE_DUMP_CSUM_EN
            last_n     = 1'b0;
            csum_n     = csum ^ rf_rdata;
`else
            last_n     = (ptr == end_ptr);
`endif
            ptr_n      = ptr + 1'b1;
        end

        if (finish) begin
            valid_n = 1'b0;
            last_n  = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
        end
    end

endmodule
